// File: rtl/logic_arbiter_i8.sv
// Round-robin arbiter sharing one registered 8-bit logic unit (OR/AND/XOR/NOR)
// among four requesters; one transaction in flight, IDLE -> EXEC -> RESP.
module logic_arbiter_i8 #(
    parameter int NREQ = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_id,
    output logic [7:0]          rsp_y,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ptr;
    logic [1:0]      r_op;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [1:0]      r_id;
    logic [7:0]      r_rsp_y;
    logic [1:0]      r_rsp_id;
    logic            r_rsp_valid;

    logic [1:0]      w_grant;
    logic            w_grant_hit;
    logic [1:0]      w_scan_idx;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;
    logic [7:0]      w_lu_y;

    function automatic logic [7:0] lu_eval(
        input logic [1:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] y;
        case (op)
            2'b00:   y = a | b;
            2'b01:   y = a & b;
            2'b10:   y = a ^ b;
            2'b11:   y = ~(a | b);
            default: y = 8'h00;
        endcase
        return y;
    endfunction

    // Round-robin search: scan from the farthest slot back toward ptr so the
    // nearest valid requester (ptr, ptr+1, ... wrapping) is the last writer.
    always_comb begin
        w_grant     = 2'd0;
        w_grant_hit = 1'b0;
        w_scan_idx  = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan_idx = r_ptr + 2'(k);
            if (req_valid[w_scan_idx]) begin
                w_grant     = w_scan_idx;
                w_grant_hit = 1'b1;
            end else begin
                w_grant     = w_grant;
                w_grant_hit = w_grant_hit;
            end
        end
    end

    // Next-state and grant strobe; req_ready is only offered from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_hit && reset) begin
                    w_req_ready[w_grant] = 1'b1;
                    w_accept             = 1'b1;
                    w_state_nxt          = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_lu_y = lu_eval(r_op, r_a, r_b);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted requester's operands and advance the pointer past it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr <= 2'd0;
            r_op  <= 2'd0;
            r_a   <= 8'h00;
            r_b   <= 8'h00;
            r_id  <= 2'd0;
        end else if (w_accept) begin
            r_ptr <= w_grant + 2'd1;
            r_op  <= req_op[{w_grant, 1'b0} +: 2];
            r_a   <= req_a[{w_grant, 3'b000} +: 8];
            r_b   <= req_b[{w_grant, 3'b000} +: 8];
            r_id  <= w_grant;
        end else begin
            r_ptr <= r_ptr;
            r_op  <= r_op;
            r_a   <= r_a;
            r_b   <= r_b;
            r_id  <= r_id;
        end
    end

    // Result register: loaded in EXEC, held stable through RESP until taken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rsp_y     <= 8'h00;
            r_rsp_id    <= 2'd0;
            r_rsp_valid <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_y     <= w_lu_y;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_y     <= r_rsp_y;
            r_rsp_id    <= r_rsp_id;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_y     <= r_rsp_y;
            r_rsp_id    <= r_rsp_id;
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logic_arbiter_i8.sv
// Bench for logic_arbiter_i8: transaction-level reference model checked every
// cycle, plus directed scenarios pinned to hand-computed literal results.
module tb_logic_arbiter_i8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic_arbiter_i8 #(.NREQ(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
        if (op == 0) return a | b;
        if (op == 1) return a & b;
        if (op == 2) return a ^ b;
        return ~(a | b);
    endfunction

    function automatic int find_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Transaction-level model: one outstanding job with its age in cycles.
    bit         m_known = 1'b0;
    bit         m_out   = 1'b0;
    int         m_age   = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    logic [7:0] m_y     = 8'h00;

    initial begin
        int g;
        logic [3:0] exp_rr;
        forever begin
            @(negedge clock);
            g = find_grant(req_valid, m_ptr);
            if (m_known) begin
                exp_rr = (reset && !m_out && g >= 0) ? (4'b0001 << g) : 4'b0000;
                chk("req_ready", req_ready, exp_rr);
                chk("rsp_valid", rsp_valid, (m_out && m_age >= 2));
                chk("busy", busy, m_out);
                if (m_out && m_age >= 2) begin
                    chk("rsp_y", rsp_y, m_y);
                    chk("rsp_id", rsp_id, m_id);
                end
            end
            if (!reset) begin
                m_known = 1'b1; m_out = 1'b0; m_ptr = 0; m_age = 0;
            end else if (m_known) begin
                if (m_out) begin
                    if (m_age >= 2 && rsp_ready) m_out = 1'b0;
                    else if (m_age < 2) m_age++;
                end else if (g >= 0) begin
                    m_out = 1'b1; m_age = 1; m_id = g;
                    m_y = ref_op(int'(req_op[2*g +: 2]), req_a[8*g +: 8], req_b[8*g +: 8]);
                    m_ptr = (g + 1) % 4;
                end
            end
        end
    end

    task automatic drive_req(input int i, input int op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = 2'(op);
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic issue(input int i, input int op, input logic [7:0] a, input logic [7:0] b,
                         output int acc);
        drive_req(i, op, a, b);
        req_valid[i] = 1'b1;
        acc = -1;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (req_ready[i]) begin
                acc = cyc;
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
        req_valid[i] = 1'b0;
        chk("accepted", (acc >= 0), 1'b1);
    endtask

    task automatic wait_rsp(output int rc, output logic [7:0] y, output logic [1:0] id);
        rc = -1; y = 8'h00; id = 2'd0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (rsp_valid) begin
                rc = cyc; y = rsp_y; id = rsp_id;
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("rsp_seen", (rc >= 0), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        int n, rc;
        int ids[5];
        int cs[5];
        int cnt;
        logic [7:0] y;
        logic [1:0] id;
        logic [7:0] exp3 [3];
        int op3 [3];
        logic [7:0] a3 [3];
        logic [7:0] b3 [3];

        reset = 1'b0; req_valid = 4'b0; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1; reset = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_y", rsp_y, 8'h00);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        @(posedge clock); #1;

        // Basic OR with latency check.
        issue(0, 0, 8'd3, 8'd8, n);
        wait_rsp(rc, y, id);
        chk("or_y", y, 8'd11);
        chk("or_id", id, 2'd0);
        chk("or_latency", rc - n, 2);

        // XOR / AND / NOR on requester 2.
        op3 = '{2, 1, 3}; a3 = '{8'hFF, 8'hF0, 8'h00}; b3 = '{8'h0F, 8'h3C, 8'h00};
        exp3 = '{8'hF0, 8'h30, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            issue(2, op3[k], a3[k], b3[k], n);
            wait_rsp(rc, y, id);
            chk("r2_y", y, exp3[k]);
            chk("r2_id", id, 2'd2);
        end

        // All four requesting: round-robin order and 3-cycle spacing.
        do_reset();
        for (int i = 0; i < 4; i++) drive_req(i, $urandom_range(0, 3), 8'($urandom), 8'($urandom));
        req_valid = 4'hF;
        cnt = 0;
        for (int t = 0; t < 30 && cnt < 5; t++) begin
            #1;
            if (req_ready != 4'b0) begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) ids[cnt] = j;
                cs[cnt] = cyc;
                cnt++;
            end
            @(posedge clock); #1;
        end
        req_valid = 4'b0;
        chk("rr_count", cnt, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", ids[k], k % 4);
        for (int k = 1; k < 5; k++) chk("rr_spacing", cs[k] - cs[k-1], 3);
        repeat (4) @(posedge clock); #1;

        // Back-pressure on the response.
        do_reset();
        rsp_ready = 1'b0;
        issue(1, 3, 8'h5A, 8'h0F, n);
        wait_rsp(rc, y, id);
        chk("bp_y", y, 8'hA0);
        chk("bp_id", id, 2'd1);
        req_valid = 4'b1101;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_hold_y", rsp_y, 8'hA0);
            chk("bp_hold_id", rsp_id, 2'd1);
            chk("bp_busy", busy, 1'b1);
            chk("bp_req_ready", req_ready, 4'b0000);
            @(posedge clock); #1;
        end
        req_valid = 4'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #2;
        chk("bp_release_valid", rsp_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);
        @(posedge clock); #1;

        // Reset during EXEC aborts; pointer returns to 0.
        do_reset();
        issue(1, 0, 8'h01, 8'h02, n);
        wait_rsp(rc, y, id);
        issue(2, 0, 8'h11, 8'h22, n);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("abort_valid", rsp_valid, 1'b0);
            chk("abort_busy", busy, 1'b0);
            @(posedge clock); #1;
        end
        req_valid = 4'b1010;
        #1;
        chk("abort_ptr0", req_ready, 4'b0010);
        req_valid = 4'b0000;
        @(posedge clock); #1;
        issue(3, 1, 8'hC3, 8'h5A, n);
        wait_rsp(rc, y, id);
        chk("r3_y", y, 8'h42);
        chk("r3_id", id, 2'd3);

        // Pointer wrap after granting 3: requester 0 beats 3.
        req_valid = 4'b1001;
        cnt = -1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (req_ready != 4'b0) begin
                cnt = int'(req_ready);
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("wrap_grant", cnt, 32'd1);
        req_valid = 4'b0;
        repeat (4) @(posedge clock); #1;

        // Randomized traffic against the model.
        for (int t = 0; t < 2500; t++) begin
            reset = ($urandom_range(0, 149) != 0);
            req_valid = 4'($urandom) & 4'($urandom | $urandom);
            req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        reset = 1'b1; req_valid = 4'b0; rsp_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_arbiter_i8.md
LOGIC_ARBITER_I8 -- requirements
Module: logic_arbiter_i8

Interface
- REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4; id width 2).
- REQ-002 Port: clock  input  1  single clock; all state updates on posedge clock.
- REQ-003 Port: reset  input  1  synchronous, active-low reset (asserted when 0, sampled at posedge clock).
- REQ-004 Port: req_valid  input  NREQ  per-requester request valid.
- REQ-005 Port: req_ready  output  NREQ  per-requester accept strobe; at most one bit set per cycle.
- REQ-006 Port: req_op  input  2*NREQ  op for requester i in bits [2i+1:2i].
- REQ-007 Port: req_a  input  8*NREQ  operand a for requester i in bits [8i+7:8i].
- REQ-008 Port: req_b  input  8*NREQ  operand b for requester i in bits [8i+7:8i].
- REQ-009 Port: rsp_valid  output  1  result valid.
- REQ-010 Port: rsp_ready  input  1  result consumer ready.
- REQ-011 Port: rsp_id  output  2  index of the requester that owns rsp_y.
- REQ-012 Port: rsp_y  output  8  result.
- REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
- REQ-014 The block SHALL share one registered 8-bit logic unit among NREQ requesters via an FSM with states IDLE, EXEC, RESP.
- REQ-015 Op encoding SHALL be 00 = a|b, 01 = a&b, 10 = a^b, 11 = ~(a|b); all 8 bits wide, no carry or sign.
- REQ-016 In IDLE, grant SHALL be the first i with req_valid[i]=1 searched from ptr upward, wrapping NREQ-1 -> 0; req_ready[grant] SHALL be 1 combinationally in that cycle, all other req_ready bits 0.
- REQ-017 req_ready SHALL be all-zero in EXEC and RESP, and in IDLE when no req_valid bit is set.
- REQ-018 On a handshake (req_valid[i] & req_ready[i]), op/a/b/i SHALL be captured, ptr SHALL become (i+1) mod NREQ, and state SHALL become EXEC.
- REQ-019 IDLE with no valid request SHALL hold state and ptr.
- REQ-020 EXEC SHALL register the op result into rsp_y and the id into rsp_id, then go to RESP unconditionally.
- REQ-021 RESP SHALL drive rsp_valid=1 with rsp_y and rsp_id stable until rsp_valid & rsp_ready, then go to IDLE with rsp_valid=0 on the next cycle.
- REQ-022 Latency SHALL be: accept at cycle N, rsp_valid first high at cycle N+2; maximum throughput one transaction per 3 cycles.
- REQ-023 Requesters whose req_valid drops before a grant SHALL be skipped; req inputs of ungranted requesters SHALL have no effect.
- REQ-024 A request presented while busy SHALL wait; it SHALL NOT be lost or reordered relative to round-robin priority.

Reset
- REQ-025 While reset=0 at a clock edge: state SHALL be IDLE, ptr 0, rsp_valid 0, rsp_y 8'h00, rsp_id 0, busy 0, req_ready all 0 in the following cycle.
- REQ-026 Reset asserted during EXEC or RESP SHALL abort the transaction with no rsp_valid pulse for it.
- REQ-027 The first grant after reset release SHALL start its search at requester 0.

Verification
- REQ-028 Requester 0, op 00, a=3, b=8, rsp_ready=1 -> rsp_valid at N+2, rsp_y=11, rsp_id=0.
- REQ-029 Requester 2, op 10, a=8'hFF, b=8'h0F; op 01, a=8'hF0, b=8'h3C; op 11, a=0, b=0 -> rsp_y=8'hF0, 8'h30, 8'hFF respectively, rsp_id=2.
- REQ-030 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; accepts spaced exactly 3 cycles apart; req_ready one-hot.
- REQ-031 Requester 1 accepted, rsp_ready=0 for 5 cycles -> rsp_valid high with rsp_y/rsp_id constant, req_ready all 0, busy=1; release -> IDLE next cycle.
- REQ-032 reset=0 asserted during EXEC -> no rsp_valid, ptr=0, busy=0; next request from requester 3 alone is granted and returns correct rsp_y with rsp_id=3.
- REQ-033 Grant requester 3, then requesters 0 and 3 both valid -> requester 0 granted next (ptr wrap).
